// File: rtl/ysyx_22050243_lsu_ctrl.sv
// ysyx_22050243_lsu_ctrl: EX-to-dmem load/store sequencer (lane mask, store shift, load extend); define LSU_MISALIGN_CHECK_EN to reject misaligned ops
module ysyx_22050243_lsu_ctrl #(
  parameter int WIDTH = 64,
  parameter int AW = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mem_w,
  input  logic             req_mem_r,
  input  logic [2:0]       req_funct3,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [7:0]       mem_wmask,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_R, ERR, RESP} state_t;
  state_t state;
  logic [2:0] funct3, off;
  logic [WIDTH-1:0] d, load_data;
  logic [7:0] base;
  logic misalign, bad;
  always_comb begin
    d = mem_rdata >> {off, 3'b000};
    load_data = funct3[1:0] == 2'b00 ? {{(WIDTH-8){~funct3[2] & d[7]}}, d[7:0]} :
                funct3[1:0] == 2'b01 ? {{(WIDTH-16){~funct3[2] & d[15]}}, d[15:0]} :
                funct3[1:0] == 2'b10 ? {{(WIDTH-32){~funct3[2] & d[31]}}, d[31:0]} : d;
    base = req_funct3[1:0] == 2'b00 ? 8'h01 :
           req_funct3[1:0] == 2'b01 ? 8'h03 :
           req_funct3[1:0] == 2'b10 ? 8'h0F : 8'hFF;
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = (req_funct3[1:0] == 2'b01 & req_addr[0]) |
               (req_funct3[1:0] == 2'b10 & |req_addr[1:0]) |
               (req_funct3[1:0] == 2'b11 & |req_addr[2:0]);
`else
    misalign = 1'b0;
`endif
    bad = misalign | (req_mem_w ? req_funct3[2] : req_funct3 == 3'b111);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b1;
      funct3 <= '0;
      off <= '0;
      mem_valid <= 1'b0;
      mem_wen <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid && (req_mem_w || req_mem_r)) begin
          req_ready <= 1'b0;
          funct3 <= req_funct3;
          off <= req_addr[2:0];
          if (bad) state <= ERR;
          else begin
            state <= ISSUE;
            mem_valid <= 1'b1;
            mem_wen <= req_mem_w;
            mem_addr <= {req_addr[AW-1:3], 3'b000};
            mem_wmask <= req_mem_w ? base << req_addr[2:0] : 8'h00;
            mem_wdata <= req_mem_w ? req_wdata << {req_addr[2:0], 3'b000} : '0;
          end
        end
        ISSUE: if (mem_ready) begin
          mem_valid <= 1'b0;
          mem_wen <= 1'b0;
          mem_addr <= '0;
          mem_wdata <= '0;
          mem_wmask <= '0;
          if (mem_wen || mem_rvalid) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_wen ? '0 : load_data;
          end else state <= WAIT_R;
        end
        WAIT_R: if (mem_rvalid) begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data;
        end
        ERR: begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
